// File: rtl/demux_1to5.sv
// Registered one-to-five demultiplexer: routes din to the output chosen by sel,
// zeroes the rest, strobes a one-hot out_valid and keeps a sticky illegal-select flag.
module demux_1to5 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [4:0]       out_valid,
  output logic             sel_err
);

  // out_valid is a push-only strobe: bit k-1 high for one cycle means outk holds
  // a word this cycle; there is no ready, the consumer must take every strobe.
  logic [4:0] hit;
  logic       illegal;

  always_comb begin
    hit = 5'b00000;
    if (en) begin
      case (sel)
        3'd0:    hit = 5'b00001;
        3'd1:    hit = 5'b00010;
        3'd2:    hit = 5'b00100;
        3'd3:    hit = 5'b01000;
        3'd4:    hit = 5'b10000;
        default: hit = 5'b00000;
      endcase
    end
  end

  assign illegal = en && (sel > 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out4      <= '0;
      out5      <= '0;
      out_valid <= 5'b00000;
      sel_err   <= 1'b0;
    end else begin
      out1      <= hit[0] ? din : '0;
      out2      <= hit[1] ? din : '0;
      out3      <= hit[2] ? din : '0;
      out4      <= hit[3] ? din : '0;
      out5      <= hit[4] ? din : '0;
      out_valid <= hit;
      // A new illegal select beats a simultaneous clear.
      if (illegal)      sel_err <= 1'b1;
      else if (err_clr) sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux_1to5.sv
// Directed plus random bench for demux_1to5 (WIDTH=8) against an array-based
// reference model of the routing and sticky-error rules.
module tb_demux_1to5;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             en = 1'b0;
  logic [2:0]       sel = 3'd0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] out1, out2, out3, out4, out5;
  logic [4:0]       out_valid;
  logic             sel_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] exp_out [5];
  logic             exp_err;

  demux_1to5 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .sel(sel), .err_clr(err_clr),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
    .out_valid(out_valid), .sel_err(sel_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model
  task automatic model_reset();
    for (int k = 0; k < 5; k++) exp_out[k] = '0;
    exp_err = 1'b0;
  endtask

  task automatic model_apply();
    int s;
    s = int'(sel);
    for (int k = 0; k < 5; k++) exp_out[k] = (en && s == k) ? din : '0;
    if (en && s >= 5) exp_err = 1'b1;
    else if (err_clr) exp_err = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [4:0] exp_valid;
    logic [WIDTH-1:0] obs [5];
    int ones;
    obs[0] = out1; obs[1] = out2; obs[2] = out3; obs[3] = out4; obs[4] = out5;
    exp_valid = '0;
    if (rst_n) begin
      for (int k = 0; k < 5; k++) begin
        // a routed word is marked valid even when it is zero
        if (en && int'(sel) == k) exp_valid[k] = 1'b1;
      end
    end
    for (int k = 0; k < 5; k++) check($sformatf("%s.out%0d", tag, k + 1), obs[k], exp_out[k]);
    check({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(exp_valid));
    check({tag, ".sel_err"}, WIDTH'(sel_err), WIDTH'(exp_err));
    ones = 0;
    for (int k = 0; k < 5; k++) if (out_valid[k]) ones++;
    check({tag, ".onehot"}, WIDTH'(ones <= 1), WIDTH'(1));
  endtask

  // driver tasks
  task automatic drive(input logic [WIDTH-1:0] d, input logic e, input logic [2:0] s, input logic c);
    @(negedge clk);
    din = d; en = e; sel = s; err_clr = c;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_apply();
    compare_all(tag);
  endtask

  task automatic step(input string tag, input logic [WIDTH-1:0] d, input logic e,
                      input logic [2:0] s, input logic c);
    drive(d, e, s, c);
    tick(tag);
  endtask

  logic [2:0] sweep [6];

  initial begin
    sweep[0] = 3'd0; sweep[1] = 3'd1; sweep[2] = 3'd2;
    sweep[3] = 3'd3; sweep[4] = 3'd4; sweep[5] = 3'd0;
    model_reset();

    // reset with active-looking inputs: outputs stay zero
    din = 8'd1; sel = 3'd0; en = 1'b1;
    #1 compare_all("rst0");
    repeat (2) @(posedge clk);
    #1 compare_all("rst2");
    drive(8'd1, 1'b1, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick("rel");

    // sweep
    for (int i = 0; i < 6; i++) step($sformatf("sweep%0d", i), 8'd1, 1'b1, sweep[i], 1'b0);

    // zero routing
    step("zero", 8'd0, 1'b1, 3'd2, 1'b0);

    // enable gating, including an illegal sel
    step("gate3", 8'd1, 1'b0, 3'd3, 1'b0);
    step("gate6", 8'd1, 1'b0, 3'd6, 1'b0);

    // illegal select and sticky error
    step("ill5", 8'd1, 1'b1, 3'd5, 1'b0);
    step("after", 8'd1, 1'b1, 3'd1, 1'b0);
    step("setwin", 8'd1, 1'b1, 3'd7, 1'b1);
    step("clr", 8'd1, 1'b0, 3'd7, 1'b1);

    // wide data
    step("wideA5", 8'hA5, 1'b1, 3'd4, 1'b0);
    step("wide3C", 8'h3C, 1'b1, 3'd0, 1'b0);

    // async reset mid-cycle
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all("async");
    @(posedge clk);
    #1 compare_all("async_hold");
    drive(8'h5A, 1'b1, 3'd3, 1'b0);
    rst_n = 1'b1;
    tick("rel2");

    // error set, then lost through reset
    step("ill6", 8'h11, 1'b1, 3'd6, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 model_reset();
    compare_all("rst_err");
    drive(8'h00, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick("rel3");

    // random
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i), WIDTH'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
